unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
Shares one single-ported memory between the core's instruction-fetch port (read-only) and data port (read/write). Sits between the core's imem/dmem interfaces and the unified memory model. Grants one transaction at a time, with dmem priority and a bound on imem starvation. A timeout watchdog ensures an unanswered memory access cannot hang the core.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive dmem grants with imem pending before imem is forced
TIMEOUT, 64, max WAIT cycles before error completion (0 = watchdog disabled)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (reset==0 resets on posedge clk)
imem_req  in  1  fetch request, held until imem_ready
imem_addr  in  ADDR_W  fetch byte address
imem_data  out  DATA_W  fetched word, valid with imem_ready
imem_ready  out  1  one-cycle completion pulse
dmem_req  in  1  data request, held until dmem_ready
dmem_we  in  1  1=store, 0=load
dmem_addr  in  ADDR_W  data byte address
dmem_wdata  in  DATA_W  store data
dmem_rdata  out  DATA_W  load data, valid with dmem_ready
dmem_ready  out  1  one-cycle completion pulse
mem_req  out  1  one-cycle issue pulse to memory
mem_we  out  1  write enable, valid with mem_req
mem_addr  out  ADDR_W  address, held from ISSUE through WAIT
mem_wdata  out  DATA_W  write data, held from ISSUE through WAIT
mem_rdata  in  DATA_W  read data, valid with mem_ready
mem_ready  in  1  memory completion pulse
busy  out  1  state != IDLE
err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; starvation counter and timeout counter 0.
  - All outputs 0, including data buses and err.
  - Reset mid-transaction abandons the transaction; a late mem_ready is ignored because it arrives in IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE: samples requests.
  - Only dmem_req -> grant D. Only imem_req -> grant I.
  - Both pending -> grant D, unless starve_cnt==STARVE_LIMIT, then grant I.
  - On a grant: latch owner, addr, we (forced 0 for I), wdata; go to ISSUE.
  - No request -> stay in IDLE.
- ISSUE (exactly 1 cycle): mem_req=1, mem_we/addr/wdata driven; go to WAIT.
- WAIT: mem_req=0; addr/we/wdata held.
  - mem_ready=1 -> capture mem_rdata into owner's data output register; go to RESP.
  - TIMEOUT!=0 and timeout_cnt reaches TIMEOUT-1 without mem_ready -> set err, owner data register=0, go to RESP.
  - mem_ready in the same cycle as the timeout: mem_ready wins, err is not set.
- RESP (1 cycle): owner's ready=1; other port's ready=0; requests ignored; go to IDLE.
  - A requester must drop req by the cycle after ready. A req still high in IDLE is a new request.
- Latency: request seen in IDLE cycle t -> mem_req at t+1 -> with memory answering next cycle, mem_ready at t+2 -> ready at t+3.
  - Minimum 4 cycles per transaction; back-to-back grant possible in the cycle after RESP.
- Starvation counter:
  - Increments on each D grant while imem_req=1, saturating at STARVE_LIMIT.
  - Clears on an I grant or whenever IDLE sees imem_req=0.
- Store responses: dmem_ready pulses and dmem_rdata keeps its previous value.
- imem_data/dmem_rdata hold their value between completions.
- Ready pulses are mutually exclusive, and neither occurs outside RESP.
- Unused low address bits pass through unchanged; the arbiter performs no alignment.

Decomposition:
- Shared package mem_arb_pkg: state enum {IDLE, ISSUE, WAIT, RESP}, owner enum {OWN_I, OWN_D}, default width constants.
- One natural sub-module: mem_arb_prio, the combinational grant decision plus the starvation counter.
- FSM, latches and watchdog stay in the top module.

Test Plan:
- Lone load: dmem_req, we=0, addr=0x0; memory returns 0x12345678 one cycle after mem_req -> dmem_ready pulses at t+3 with dmem_rdata=0x12345678; mem_req is a single pulse.
- Lone fetch: imem_req, addr=0x8, inst_mem[2]=0x024183B3 -> imem_data=0x024183B3 with imem_ready at t+3; mem_we=0.
- Contention and starvation: imem_req held high while dmem issues 6 back-to-back loads, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D; imem_ready after the 4th dmem_ready.
- Store: dmem_we=1, addr=0x4, wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF with mem_req; dmem_ready pulses; dmem_rdata unchanged.
- Timeout: TIMEOUT=8, memory never answers -> ready to owner 8 WAIT cycles after ISSUE, data=0, err=1 and sticky; next transaction still completes normally.
- Reset mid-WAIT: reset=0 for 1 cycle, then a stale mem_ready -> outputs 0, state IDLE, no ready pulse generated.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory arbiter.
// Imported by the arbiter top and its grant sub-block.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int STARVE_DEF  = 4;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and data ports.
// Data wins unless fetch has waited STARVE_LIMIT grants.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   idle_i,
  input  logic   imem_req_i,
  input  logic   dmem_req_i,
  output logic   gnt_o,
  output owner_e owner_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q;
  logic [CW-1:0] starve_d;
  logic          at_limit;

  assign at_limit = (starve_q == LIMIT);

  // combinational grant: only meaningful while the FSM is idle
  always_comb begin
    gnt_o   = idle_i & (imem_req_i | dmem_req_i);
    owner_o = OWN_I;
    if (dmem_req_i && !(imem_req_i && at_limit))
      owner_o = OWN_D;
  end

  // starvation counter next state, saturating at the limit
  always_comb begin
    starve_d = starve_q;
    if (idle_i) begin
      if (!imem_req_i || (gnt_o && owner_o == OWN_I))
        starve_d = '0;
      else if (gnt_o && !at_limit)
        starve_d = starve_q + 1'b1;
    end
  end

  // starvation counter register
  always_ff @(posedge clk) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-ported memory shared by fetch and data ports.
// One transaction at a time, registered outputs, watchdog.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_data,
  output logic              imem_ready,
  input  logic              dmem_req,
  input  logic              dmem_we,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] idata_q, idata_d;
  logic [DATA_W-1:0] ddata_q, ddata_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              we_q, we_d;
  logic              mreq_q, mreq_d;
  logic              irdy_q, irdy_d;
  logic              drdy_q, drdy_d;
  logic              err_q, err_d;
  logic              gnt;
  owner_e            gnt_own;
  logic              tmo;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk        (clk),
    .reset      (reset),
    .idle_i     (state_q == IDLE),
    .imem_req_i (imem_req),
    .dmem_req_i (dmem_req),
    .gnt_o      (gnt),
    .owner_o    (gnt_own)
  );

  assign tmo = (TIMEOUT != 0) && (tcnt_q == TLAST);

  // next state, latches and watchdog
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    idata_d = idata_q;
    ddata_d = ddata_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    mreq_d  = 1'b0;
    irdy_d  = 1'b0;
    drdy_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          state_d = ISSUE;
          owner_d = gnt_own;
          mreq_d  = 1'b1;
          tcnt_d  = '0;
          if (gnt_own == OWN_D) begin
            addr_d  = dmem_addr;
            we_d    = dmem_we;
            wdata_d = dmem_wdata;
          end else begin
            addr_d  = imem_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_ready || tmo) begin
          state_d = RESP;
          irdy_d  = (owner_q == OWN_I);
          drdy_d  = (owner_q == OWN_D);
          if (!mem_ready) begin
            err_d = 1'b1;
            if (owner_q == OWN_I) idata_d = '0;
            else                  ddata_d = '0;
          end else if (owner_q == OWN_I) begin
            idata_d = mem_rdata;
          end else if (!we_q) begin
            ddata_d = mem_rdata;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      idata_q <= '0;
      ddata_q <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      mreq_q  <= 1'b0;
      irdy_q  <= 1'b0;
      drdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      idata_q <= idata_d;
      ddata_q <= ddata_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      mreq_q  <= mreq_d;
      irdy_q  <= irdy_d;
      drdy_q  <= drdy_d;
    end
  end

  assign mem_req    = mreq_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign imem_data  = idata_q;
  assign imem_ready = irdy_q;
  assign dmem_rdata = ddata_q;
  assign dmem_ready = drdy_q;
  assign busy       = (state_q != IDLE);
  assign err        = err_q;

endmodule
